mod_delay: RTL and testbench

- Parametrised modulated delay line: one engine for flanger, chorus, vibrato and fixed-echo voices in the synth output chain, runtime-programmable.
- Sits after the voice mixer and before the DAC/PWM stage, processing one offset-binary sample per din_valid strobe on the system clock.
- Adds behaviour the basic flanger lacks:
  - runtime LFO rate, depth and base delay;
  - signed feedback with saturation;
  - wet/dry mix;
  - valid/busy handshake;
  - RAM clear after reset.

---
 rtl/mod_delay_pkg.sv | 28 ++
 rtl/lfo_triangle.sv | 26 ++
 rtl/mod_delay.sv | 148 ++++++++++++++
 tb/tb_mod_delay.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_delay_pkg.sv
// Shared types and constants for the modulated delay line.
// Saturation helper is width-generic so feedback and mix paths share it.
package mod_delay_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    READ,
    WAIT,
    CALC,
    WRITE
  } state_t;

  localparam int FB_SHIFT  = 7;
  localparam int MIX_SCALE = 256;
  localparam int MIX_SHIFT = $clog2(MIX_SCALE);

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/lfo_triangle.sv
// LFO phase accumulator with triangle fold; advances by rate on each advance strobe.
// Output is combinational from the phase register; no backpressure.
module lfo_triangle
  import mod_delay_pkg::*;
#(
  parameter int PHASE_BITS = 24,
  parameter int TRI_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic [PHASE_BITS-1:0] rate,
  output logic [TRI_BITS-1:0]   tri_val
);

  logic [PHASE_BITS-1:0] phase_q;

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else if (advance) phase_q <= phase_q + rate;
  end

  assign tri_val = phase_q[PHASE_BITS-1] ? ~phase_q[PHASE_BITS-2 -: TRI_BITS]
                                         :  phase_q[PHASE_BITS-2 -: TRI_BITS];

endmodule

// File: rtl/mod_delay.sv
// Modulated delay line (flanger/chorus/vibrato/echo) with feedback and wet/dry mix.
// dout_valid 4 cycles after acceptance, one sample per 5 cycles; din_valid while busy is dropped and flagged.
module mod_delay
  import mod_delay_pkg::*;
#(
  parameter int SAMPLE_BITS = 12,
  parameter int DELAY_BITS  = 10,
  parameter int PHASE_BITS  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] din,
  input  logic                   din_valid,
  input  logic [PHASE_BITS-1:0]  rate,
  input  logic [7:0]             depth,
  input  logic [DELAY_BITS-1:0]  base_delay,
  input  logic [7:0]             feedback,
  input  logic [7:0]             mix,
  output logic [SAMPLE_BITS-1:0] dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int DEPTH = 1 << DELAY_BITS;
  localparam logic [DELAY_BITS:0] TAP_MAX = (DELAY_BITS+1)'(DEPTH - 1);

  state_t state_q, state_d;

  logic [DELAY_BITS-1:0]         clr_addr_q, wr_ptr_q, rd_addr_q;
  logic signed [SAMPLE_BITS-1:0] s_in_q, wet_q, fb_word_q, out_word_q;
  logic [SAMPLE_BITS-1:0]        ram_q;
  logic [PHASE_BITS-1:0]         rate_q;
  logic signed [7:0]             fb_gain_q;
  logic [7:0]                    mix_q;

  logic [SAMPLE_BITS-1:0] ram [DEPTH];
  logic                   ram_we;
  logic [DELAY_BITS-1:0]  ram_waddr;
  logic [SAMPLE_BITS-1:0] ram_wdata;

  logic                   accept;
  logic [DELAY_BITS-1:0]  tri_val;
  logic [DELAY_BITS+7:0]  mod_prod;
  logic [DELAY_BITS:0]    tap_sum;
  logic [DELAY_BITS-1:0]  tap;

  lfo_triangle #(
    .PHASE_BITS(PHASE_BITS),
    .TRI_BITS  (DELAY_BITS)
  ) u_lfo (
    .clk    (clk),
    .rst    (rst),
    .advance(state_q == WRITE),
    .rate   (rate_q),
    .tri_val(tri_val)
  );

  assign accept   = (state_q == IDLE) && din_valid;
  assign mod_prod = (DELAY_BITS+8)'(tri_val) * (DELAY_BITS+8)'(depth);

  // Tap of zero would read the slot being overwritten, so it is pushed to one.
  always_comb begin
    tap_sum = {1'b0, base_delay} + (DELAY_BITS+1)'(mod_prod >> 8);
    if (tap_sum == '0) tap = DELAY_BITS'(1);
    else if (tap_sum > TAP_MAX) tap = DELAY_BITS'(DEPTH - 1);
    else tap = tap_sum[DELAY_BITS-1:0];
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE) || rst;
    overrun    = din_valid && (state_q != IDLE) && !rst;
    dout_valid = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = clr_addr_q;
    ram_wdata  = '0;
    unique case (state_q)
      CLEAR: begin
        ram_we = !rst;
        if (clr_addr_q == DELAY_BITS'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE:  if (din_valid) state_d = READ;
      READ:  state_d = WAIT;
      WAIT:  state_d = CALC;
      CALC:  state_d = WRITE;
      WRITE: begin
        dout_valid = !rst;
        ram_we     = !rst;
        ram_waddr  = wr_ptr_q;
        ram_wdata  = fb_word_q;
        state_d    = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_q <= ram[rd_addr_q];
  end

  logic signed [31:0] s_ext, wet_ext, fb_ext, dry_gain, wet_gain, fb_sum, mix_sum;

  assign s_ext    = 32'(s_in_q);
  assign wet_ext  = 32'(wet_q);
  assign fb_ext   = 32'(fb_gain_q);
  assign wet_gain = 32'(mix_q);
  assign dry_gain = MIX_SCALE - 32'(mix_q);
  assign fb_sum   = s_ext + ((wet_ext * fb_ext) >>> FB_SHIFT);
  // Mix uses the dry input before feedback; the weights sum to unity so it cannot overflow.
  assign mix_sum  = (s_ext * dry_gain + wet_ext * wet_gain) >>> MIX_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_addr_q  <= '0;
      s_in_q     <= '0;
      wet_q      <= '0;
      fb_word_q  <= '0;
      out_word_q <= '0;
      rate_q     <= '0;
      fb_gain_q  <= '0;
      mix_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_addr_q <= clr_addr_q + DELAY_BITS'(1);
      if (accept) begin
        s_in_q    <= {~din[SAMPLE_BITS-1], din[SAMPLE_BITS-2:0]};
        rate_q    <= rate;
        fb_gain_q <= feedback;
        mix_q     <= mix;
        rd_addr_q <= wr_ptr_q - tap;
      end
      if (state_q == WAIT) wet_q <= ram_q;
      if (state_q == CALC) begin
        fb_word_q  <= SAMPLE_BITS'(sat_signed(fb_sum, SAMPLE_BITS));
        out_word_q <= SAMPLE_BITS'(sat_signed(mix_sum, SAMPLE_BITS));
      end
      if (state_q == WRITE) wr_ptr_q <= wr_ptr_q + DELAY_BITS'(1);
    end
  end

  assign dout = {~out_word_q[SAMPLE_BITS-1], out_word_q[SAMPLE_BITS-2:0]};

endmodule

// File: tb/tb_mod_delay.sv
// Scoreboard bench for mod_delay: behavioural model predicts each output at acceptance.
module tb_mod_delay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic [23:0] rate = '0;
  logic [7:0]  depth = '0;
  logic [9:0]  base_delay = '0;
  logic [7:0]  feedback = '0;
  logic [7:0]  mix = '0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        overrun;

  mod_delay dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .rate(rate),
    .depth(depth), .base_delay(base_delay), .feedback(feedback), .mix(mix),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int exp_d; int acc; } exp_t;
  exp_t sb[$];
  int   outs[$];
  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  int   n_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural reference.
  int mem [1024];
  int m_wr = 0;
  int m_phase = 0;

  function automatic int fdiv(input int a, input int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    foreach (mem[i]) mem[i] = 0;
    m_wr = 0;
    m_phase = 0;
  endtask

  function automatic int model_step(input int d, input int r, input int dp, input int b, input int f, input int m);
    int s, field, tri_v, tap, wet, g, fw, o;
    s     = d - 2048;
    field = (m_phase >> 13) & 1023;
    tri_v = ((m_phase >> 23) & 1) != 0 ? 1023 - field : field;
    tap   = b + fdiv(tri_v * dp, 256);
    if (tap == 0) tap = 1;
    if (tap > 1023) tap = 1023;
    wet = mem[(m_wr - tap + 1024) % 1024];
    g   = (f >= 128) ? f - 256 : f;
    fw  = s + fdiv(wet * g, 128);
    if (fw > 2047) fw = 2047;
    if (fw < -2048) fw = -2048;
    o = fdiv(s * (256 - m) + wet * m, 256);
    mem[m_wr] = fw;
    m_wr = (m_wr + 1) % 1024;
    m_phase = (m_phase + r) % (1 << 24);
    return o + 2048;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (overrun === 1'b1) n_ovr++;
      if (dout_valid === 1'b1) begin
        n_out++;
        outs.push_back(int'(dout));
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("dout", dout, e.exp_d);
          check("latency", cyc - e.acc, 4);
        end
      end
    end
  end

  task automatic do_reset();
    int nb = 0, bad_d = 0, bad_v = 0;
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    while (busy === 1'b1 && nb < 3000) begin
      if (dout !== 12'h800) bad_d++;
      if (dout_valid !== 1'b0) bad_v++;
      nb++;
      @(negedge clk);
      #1;
    end
    check("clr_len", nb, 1024);
    check("clr_dout", bad_d, 0);
    check("clr_vld", bad_v, 0);
    check("clr_busy_after", busy, 0);
    model_reset();
    sb.delete();
    outs.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_wait", busy, 0);
  endtask

  // Config inputs are scrambled after acceptance: only the accepted values may matter.
  task automatic send(input int d, input int r, input int dp, input int b, input int f, input int m, input bit expect_out);
    wait_idle();
    din = 12'(d); rate = 24'(r); depth = 8'(dp); base_delay = 10'(b); feedback = 8'(f); mix = 8'(m);
    din_valid = 1'b1;
    if (expect_out) sb.push_back('{exp_d: model_step(d, r, dp, b, f, m), acc: cyc});
    @(negedge clk);
    din_valid = 1'b0;
    din = 12'($urandom); rate = 24'($urandom); depth = 8'($urandom);
    base_delay = 10'($urandom); feedback = 8'($urandom); mix = 8'($urandom);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    #2;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt, ovr0, out0;
    @(negedge clk);
    do_reset();

    // Bypass: mix 0 returns the input bit-exact.
    send('h7A3, 0, 0, 0, 0, 0, 1);
    drain();
    check("bypass", outs.size() > 0 ? outs[0] : -1, 'h7A3);

    // Fixed 5-sample echo of a single impulse.
    do_reset();
    send('hFFF, 0, 0, 5, 0, 255, 1);
    for (int i = 0; i < 8; i++) send('h800, 0, 0, 5, 0, 255, 1);
    drain();
    check("fix_count", outs.size(), 9);
    if (outs.size() == 9) begin
      check("fix_impulse", outs[0], 'h807);
      check("fix_echo", outs[5], 'hFF7);
      cnt = 0;
      for (int i = 1; i < 9; i++) if (i != 5 && outs[i] != 'h800) cnt++;
      check("fix_quiet", cnt, 0);
    end

    // Full positive feedback must clamp, never wrap.
    do_reset();
    for (int i = 0; i < 50; i++) send('hFFF, 0, 0, 1, 'h7F, 255, 1);
    drain();
    check("fb_count", outs.size(), 50);
    if (outs.size() == 50) begin
      cnt = 0;
      for (int i = 1; i < 50; i++) if (outs[i] < outs[i-1] || outs[i] < 'hF00) cnt++;
      check("fb_monotonic", cnt, 0);
      check("fb_clamp", outs[49], 'hFFF);
    end

    // Back-to-back strobes: second is dropped and flagged; tap 0 reads previous sample.
    do_reset();
    send('h900, 0, 0, 0, 0, 255, 1);
    wait_idle();
    ovr0 = n_ovr;
    out0 = n_out;
    din = 12'hA00; rate = '0; depth = '0; base_delay = '0; feedback = '0; mix = 8'd255;
    din_valid = 1'b1;
    sb.push_back('{exp_d: model_step('hA00, 0, 0, 0, 0, 255), acc: cyc});
    #1 check("ovr_first", overrun, 0);
    @(negedge clk);
    #1 check("ovr_second", overrun, 1);
    @(negedge clk);
    din_valid = 1'b0;
    drain();
    check("ovr_pulses", n_ovr - ovr0, 1);
    check("ovr_outputs", n_out - out0, 1);
    check("tap_clamp", outs[outs.size()-1], 'h901);

    // Reset while in CALC: the in-flight sample never emerges.
    send('h123, 0, 0, 3, 0, 128, 0);
    @(negedge clk);
    @(negedge clk);
    out0 = n_out;
    do_reset();
    check("rst_no_output", n_out - out0, 0);

    // LFO sweep with negative feedback and half mix, over more than one LFO period.
    for (int i = 0; i < 1100; i++) send((i * 197 + 300) % 4096, 1 << 14, 255, 0, 'hC0, 128, 1);
    drain();

    // Random configuration on every sample.
    do_reset();
    for (int i = 0; i < 300; i++)
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
